// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - handshaked WIDTH-bit ALU with iterative multiply and divide
//
// Purpose: registered ALU that sits between register read and writeback.
//   Single-cycle ops (0-18) produce a result the cycle after accept. MUL/MULH
//   run a radix-2 shift-add over WIDTH cycles. DIVU/REMU run a restoring divide
//   over WIDTH cycles. While an iterative op runs, in_ready is low.
// Optional feature: macro ALU_SEQ_DIV_EN adds the DIV state and ops 21/22;
//   without it, ops 21/22 return out=0, err=1 like any illegal opcode.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   in_valid/in_ready  operation handshake (a, b, op)
//   out_valid/out_ready result handshake (out, err)
//   a, b             WIDTH-bit operands
//   op               5-bit opcode
//   out, err         registered result and error flag, qualified by out_valid
module alu_seq #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [4:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic             err
);
   localparam int SHW  = $clog2(WIDTH);
   localparam int HALF = WIDTH / 2;
   localparam logic [SHW-1:0] CNT_INIT = SHW'(WIDTH - 1);

`ifdef ALU_SEQ_DIV_EN
   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;
`else
   typedef enum logic [1:0] {S_IDLE, S_MUL} state_t;
`endif

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   out_q, out_d;
   logic [WIDTH-1:0]   opnd_q, opnd_d;
   logic               err_q, err_d;
   logic               valid_q, valid_d;
   logic               hi_q, hi_d;
   logic [SHW-1:0]     cnt_q, cnt_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;

   logic [SHW-1:0]     sh;
   logic [2*WIDTH-1:0] shl_w, shr_w;
   logic [WIDTH:0]     sum_w, mul_sum;
   logic [WIDTH-1:0]   alu_res;
   logic               alu_err;
   logic               in_ready_w;
`ifdef ALU_SEQ_DIV_EN
   logic [WIDTH:0]     div_shift, div_trial;
   logic               div_ge;
   logic [WIDTH-1:0]   div_rem;
`endif

   assign in_ready_w = (state_q == S_IDLE) && (!valid_q || out_ready);
   assign in_ready   = in_ready_w;
   assign out_valid  = valid_q;
   assign out        = out_q;
   assign err        = err_q;

   // Shifting {a,a}: upper half of the left shift is ROL, lower half is SLL;
   // lower half of the right shift is ROR, upper half is SRL.
   assign sh    = b[SHW-1:0];
   assign shl_w = {a, a} << sh;
   assign shr_w = {a, a} >> sh;
   assign sum_w = {1'b0, a} + {1'b0, b};

   always_comb begin
      alu_res = '0;
      alu_err = (op > 5'd18);
      case (op)
         5'd0:  alu_res = sum_w[WIDTH-1:0];
         5'd1:  alu_res = b - a;
         5'd2:  alu_res = a ^ b;
         5'd3:  alu_res = a & ~b;
         5'd4:  alu_res = shl_w[2*WIDTH-1:WIDTH];
         5'd5:  alu_res = shl_w[WIDTH-1:0];
         5'd6:  alu_res = shr_w[WIDTH-1:0];
         5'd7:  alu_res = shr_w[2*WIDTH-1:WIDTH];
         5'd8:  alu_res[0] = (a == b);
         5'd9:  alu_res[0] = ($signed(a) < $signed(b));
         5'd10: alu_res[0] = ($signed(a) <= $signed(b));
         5'd11: alu_res[0] = sum_w[WIDTH];
         5'd12: alu_res[0] = (a == '0);
         5'd13: alu_res[0] = (a != '0);
         5'd14: alu_res[0] = a[WIDTH-1];
         5'd15: alu_res[0] = !a[WIDTH-1];
         5'd16: alu_res = b;
         5'd17: alu_res = {a[HALF-1:0], b[HALF-1:0]};
         5'd18: begin
            for (int i = 0; i < WIDTH; i++) alu_res[i] = a[WIDTH-1-i];
         end
         default: alu_res = '0;
      endcase
   end

   // Multiply: acc holds {partial high, remaining multiplier}; add the
   // multiplicand when the multiplier LSB is set, then shift right with carry.
   assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);

`ifdef ALU_SEQ_DIV_EN
   // Divide: acc holds {remainder, dividend/quotient}; shift one dividend bit
   // into the remainder and keep the subtraction only if it does not borrow.
   assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
   assign div_trial = div_shift - {1'b0, opnd_q};
   assign div_ge    = !div_trial[WIDTH];
   assign div_rem   = div_ge ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
`endif

   always_comb begin
      state_d = state_q;
      out_d   = out_q;
      err_d   = err_q;
      valid_d = valid_q;
      hi_d    = hi_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      opnd_d  = opnd_q;
      if (valid_q && out_ready) valid_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (in_valid && in_ready_w) begin
               hi_d = (op == 5'd20) || (op == 5'd22);
               case (op)
                  5'd19, 5'd20: begin
                     state_d = S_MUL;
                     cnt_d   = CNT_INIT;
                     acc_d   = {{WIDTH{1'b0}}, b};
                     opnd_d  = a;
                  end
`ifdef ALU_SEQ_DIV_EN
                  5'd21, 5'd22: begin
                     if (b == '0) begin
                        out_d   = (op == 5'd21) ? {WIDTH{1'b1}} : a;
                        err_d   = 1'b1;
                        valid_d = 1'b1;
                     end else begin
                        state_d = S_DIV;
                        cnt_d   = CNT_INIT;
                        acc_d   = {{WIDTH{1'b0}}, a};
                        opnd_d  = b;
                     end
                  end
`endif
                  default: begin
                     out_d   = alu_res;
                     err_d   = alu_err;
                     valid_d = 1'b1;
                  end
               endcase
            end
         end
         S_MUL: begin
            acc_d = {mul_sum, acc_q[WIDTH-1:1]};
            cnt_d = cnt_q - SHW'(1);
            if (cnt_q == '0) begin
               out_d   = hi_q ? acc_d[2*WIDTH-1:WIDTH] : acc_d[WIDTH-1:0];
               err_d   = 1'b0;
               valid_d = 1'b1;
               state_d = S_IDLE;
            end
         end
`ifdef ALU_SEQ_DIV_EN
         S_DIV: begin
            acc_d = {div_rem, acc_q[WIDTH-2:0], div_ge};
            cnt_d = cnt_q - SHW'(1);
            if (cnt_q == '0) begin
               out_d   = hi_q ? acc_d[2*WIDTH-1:WIDTH] : acc_d[WIDTH-1:0];
               err_d   = 1'b0;
               valid_d = 1'b1;
               state_d = S_IDLE;
            end
         end
`endif
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         out_q   <= '0;
         err_q   <= 1'b0;
         valid_q <= 1'b0;
         hi_q    <= 1'b0;
         cnt_q   <= '0;
         acc_q   <= '0;
         opnd_q  <= '0;
      end else begin
         state_q <= state_d;
         out_q   <= out_d;
         err_q   <= err_d;
         valid_q <= valid_d;
         hi_q    <= hi_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         opnd_q  <= opnd_d;
      end
   end
endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - self-checking bench for alu_seq (WIDTH=16)
module tb_alu_seq;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] a = '0;
   logic [15:0] b = '0;
   logic [4:0]  op = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [15:0] out;
   logic        err;

   int total = 0;
   int bad   = 0;

   alu_seq #(.WIDTH(16)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
      .out(out), .err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference model: result, error flag and latency in cycles after accept.
   function automatic void model(input logic [4:0] o, input logic [15:0] x, input logic [15:0] y,
                                 output logic [15:0] r, output logic e, output int lat);
      logic [31:0] p;
      int s;
      r = '0; e = 1'b0; lat = 1; s = int'(y[3:0]);
      case (o)
         5'd0:  r = x + y;
         5'd1:  r = y - x;
         5'd2:  r = x ^ y;
         5'd3:  r = x & ~y;
         5'd4:  r = (x << s) | (x >> (16 - s));
         5'd5:  r = x << s;
         5'd6:  r = (x >> s) | (x << (16 - s));
         5'd7:  r = x >> s;
         5'd8:  r = {15'b0, x == y};
         5'd9:  r = {15'b0, $signed(x) < $signed(y)};
         5'd10: r = {15'b0, $signed(x) <= $signed(y)};
         5'd11: begin p = {16'b0, x} + {16'b0, y}; r = {15'b0, p[16]}; end
         5'd12: r = {15'b0, x == 16'd0};
         5'd13: r = {15'b0, x != 16'd0};
         5'd14: r = {15'b0, $signed(x) < 0};
         5'd15: r = {15'b0, $signed(x) >= 0};
         5'd16: r = y;
         5'd17: r = {x[7:0], y[7:0]};
         5'd18: for (int i = 0; i < 16; i++) r[i] = x[15-i];
         5'd19: begin p = {16'b0, x} * {16'b0, y}; r = p[15:0]; lat = 17; end
         5'd20: begin p = {16'b0, x} * {16'b0, y}; r = p[31:16]; lat = 17; end
`ifdef ALU_SEQ_DIV_EN
         5'd21, 5'd22: begin
            if (y == 16'd0) begin
               e = 1'b1;
               r = (o == 5'd21) ? 16'hFFFF : x;
            end else begin
               r = (o == 5'd21) ? x / y : x % y;
               lat = 17;
            end
         end
`endif
         default: e = 1'b1;
      endcase
   endfunction

   // Issue one op at a negedge, then count cycles to the result while
   // presenting junk requests that must be ignored.
   task automatic do_op(input string tag, input logic [4:0] o, input logic [15:0] x,
                        input logic [15:0] y, input logic [15:0] eo, input logic ee, input int el);
      int n;
      @(negedge clk);
      in_valid = 1'b1; op = o; a = x; b = y;
      #1 chk({tag, "_acc_rdy"}, in_ready, 1);
      @(negedge clk);
      in_valid = 1'b0;
      n = 1;
      while (out_valid !== 1'b1 && n < 40) begin
         chk({tag, "_busy_rdy"}, in_ready, 0);
         in_valid = 1'b1; op = 5'($urandom); a = 16'($urandom); b = 16'($urandom);
         @(negedge clk);
         in_valid = 1'b0;
         n++;
      end
      chk({tag, "_lat"}, n, el);
      chk({tag, "_out"}, out, eo);
      chk({tag, "_err"}, err, ee);
   endtask

   logic [4:0]  bb_op [3] = '{5'd0, 5'd1, 5'd9};
   logic [15:0] bb_a  [3] = '{16'h7FFF, 16'd3, 16'hFFFF};
   logic [15:0] bb_b  [3] = '{16'h0001, 16'd10, 16'h0001};
   logic [15:0] bb_e  [3] = '{16'h8000, 16'h0007, 16'h0001};

   initial begin
      logic [15:0] mr;
      logic        me;
      int          ml;
      logic [4:0]  ro;
      logic [15:0] ra, rb;

      // Reset state
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk("rst_valid", out_valid, 0);
      chk("rst_rdy", in_ready, 1);
      chk("rst_out", out, 0);
      chk("rst_err", err, 0);

      // Back-to-back single-cycle ops
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (i > 0) begin
            chk("b2b_valid", out_valid, 1);
            chk("b2b_out", out, bb_e[i-1]);
            chk("b2b_err", err, 0);
         end
         in_valid = 1'b1; op = bb_op[i]; a = bb_a[i]; b = bb_b[i];
         #1 chk("b2b_rdy", in_ready, 1);
      end
      @(negedge clk);
      in_valid = 1'b0;
      chk("b2b_valid", out_valid, 1);
      chk("b2b_out", out, bb_e[2]);
      chk("b2b_err", err, 0);

      // Multiply
      do_op("mul", 5'd19, 16'h1234, 16'h0100, 16'h3400, 1'b0, 17);
      do_op("mulh", 5'd20, 16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b0, 17);

      // Divide (illegal when the divider is not built)
`ifdef ALU_SEQ_DIV_EN
      do_op("divu", 5'd21, 16'd100, 16'd7, 16'd14, 1'b0, 17);
      do_op("remu", 5'd22, 16'd100, 16'd7, 16'd2, 1'b0, 17);
      do_op("div0", 5'd21, 16'd5, 16'd0, 16'hFFFF, 1'b1, 1);
      do_op("rem0", 5'd22, 16'd5, 16'd0, 16'd5, 1'b1, 1);
`else
      do_op("divu", 5'd21, 16'd100, 16'd7, 16'd0, 1'b1, 1);
      do_op("remu", 5'd22, 16'd100, 16'd7, 16'd0, 1'b1, 1);
`endif
      do_op("ill25", 5'd25, 16'h1234, 16'h5678, 16'd0, 1'b1, 1);

      // Backpressure: result held, second op waits, then accepted on release
      @(negedge clk);
      out_ready = 1'b0;
      in_valid = 1'b1; op = 5'd0; a = 16'd1; b = 16'd2;
      #1 chk("bp_acc_rdy", in_ready, 1);
      @(negedge clk);
      op = 5'd0; a = 16'd5; b = 16'd6;
      for (int k = 0; k < 5; k++) begin
         #1;
         chk("bp_valid", out_valid, 1);
         chk("bp_out", out, 16'h0003);
         chk("bp_err", err, 0);
         chk("bp_rdy", in_ready, 0);
         @(negedge clk);
      end
      out_ready = 1'b1;
      #1 chk("bp_rel_rdy", in_ready, 1);
      chk("bp_rel_out", out, 16'h0003);
      @(negedge clk);
      in_valid = 1'b0;
      chk("bp_next_valid", out_valid, 1);
      chk("bp_next_out", out, 16'd11);

      // Reset during the 8th busy cycle of a multiply
      @(negedge clk);
      in_valid = 1'b1; op = 5'd19; a = 16'hABCD; b = 16'h1357;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (7) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mrst_valid", out_valid, 0);
      chk("mrst_rdy", in_ready, 1);
      chk("mrst_out", out, 0);
      chk("mrst_err", err, 0);
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         chk("mrst_noresult", out_valid, 0);
      end

      // Randomised ops against the model
      for (int t = 0; t < 80; t++) begin
         ro = 5'($urandom_range(0, 31));
         ra = 16'($urandom);
         rb = 16'($urandom);
         if ((ro == 5'd21 || ro == 5'd22) && $urandom_range(0, 3) == 0) rb = 16'd0;
         if ($urandom_range(0, 7) == 0) ra = rb;
         model(ro, ra, rb, mr, me, ml);
         do_op($sformatf("rnd%0d_op%0d", t, ro), ro, ra, rb, mr, me, ml);
      end

      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
